timeout_timer: RTL and testbench
================================

TIMEOUT_TIMER -- requirements
Module: timeout_timer

Interface
REQ-001 Parameter: WIDTH, 16, counter and limit width in bits (2..32).
REQ-002 Parameter: PRESCALE, 1, tick cycles per count step (>=1).
REQ-003 Port: tick  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  start/restart request, sampled on tick.
REQ-006 Port: stop  input  1  halt request, sampled on tick.
REQ-007 Port: mode  input  1  mode at start: 0 one-shot, 1 periodic.
REQ-008 Port: limit  input  WIDTH  timeout value, latched at start.
REQ-009 Port: clear  input  1  clears the sticky reached flag.
REQ-010 Port: count  output  WIDTH  current step count, registered.
REQ-011 Port: running  output  1  high while in state RUN.
REQ-012 Port: reached  output  1  sticky timeout flag.
REQ-013 Port: expire  output  1  one-cycle timeout pulse.

Function
REQ-014 States SHALL be IDLE, RUN and DONE; running SHALL be 1 only in RUN.
REQ-015 start in any state SHALL latch limit into limit_q and mode into mode_q, set count=0 and prescaler=0, and enter RUN on the next edge.
REQ-016 A step SHALL occur in RUN on each edge where prescaler==PRESCALE-1; prescaler SHALL wrap to 0 on a step and increment otherwise.
REQ-017 On a step with count<limit_q, count SHALL increment by 1.
REQ-018 On a step with count==limit_q, expire SHALL be 1 for exactly the following cycle and reached SHALL be set.
REQ-019 In that expiring step, one-shot SHALL go to DONE with count held at limit_q; periodic SHALL set count=0 and stay in RUN.
REQ-020 Timeout latency from the start edge SHALL be (limit_q+1)*PRESCALE cycles; the periodic expire period SHALL equal that latency.
REQ-021 limit_q==0 SHALL expire on the first step.
REQ-022 stop in RUN SHALL enter IDLE, hold count, zero the prescaler, and suppress any step on that edge.
REQ-023 stop in IDLE or DONE SHALL have no effect.
REQ-024 start and stop on the same edge: stop SHALL win.
REQ-025 start on an edge that would otherwise expire: start SHALL win, with no expire and no reached set.
REQ-026 clear SHALL zero reached on the next edge; if reached is being set on the same edge, set SHALL win.
REQ-027 Changes to limit or mode outside a start edge SHALL be ignored.
REQ-028 count SHALL never exceed limit_q and SHALL never wrap past 2^WIDTH-1.

Reset
REQ-029 Asserting reset (reset=0) SHALL immediately force state IDLE, count=0, prescaler=0, limit_q=0, mode_q=0, running=0, reached=0 and expire=0, independent of tick.
REQ-030 Reset asserted mid-RUN SHALL abort the count; after release the block SHALL stay in IDLE until start.
REQ-031 Inputs SHALL be ignored while reset=0.

Verification
REQ-032 PRESCALE=1, limit=10, mode=0, start one cycle: expire high exactly 11 cycles after the start edge; reached=1; count=10; running=0.
REQ-033 PRESCALE=4, limit=2, mode=1: expire pulses every 12 cycles for at least 3 periods; count sequence 0,1,2,0; running stays 1.
REQ-034 limit=5 run, stop when count=3: IDLE, count holds at 3, no expire; a later start restarts from count=0 and expires 6 steps later.
REQ-035 start and stop asserted together in RUN: state becomes IDLE; clear and an expire on the same edge: reached=1.
REQ-036 Drive reset low asynchronously mid-RUN (count=7): all outputs 0 before the next tick edge; after release, no activity until start.
REQ-037 limit=0, mode=1, PRESCALE=1: expire high every cycle after the first step; count stays 0.

Source files
------------

// File: rtl/timeout_timer.sv
// Programmable timeout timer: prescaled step counter with one-shot or periodic
// expiry, a one-cycle expire pulse and a sticky reached flag.
module timeout_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic             tick,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             reached,
    output logic             expire
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] limit_q,   limit_d;
    logic [PW-1:0]    pre_q,     pre_d;
    logic             mode_q,    mode_d;
    logic             reached_q, reached_d;
    logic             expire_q,  expire_d;
    logic             step;
    logic             at_limit;
    logic             set_reached;

    assign step     = (state_q == RUN) && (pre_q == PRE_LAST);
    assign at_limit = (count_q == limit_q);

    // Priority: stop (only meaningful in RUN) over start over normal counting.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        limit_d     = limit_q;
        pre_d       = pre_q;
        mode_d      = mode_q;
        expire_d    = 1'b0;
        set_reached = 1'b0;

        if (stop && (state_q == RUN)) begin
            state_d = IDLE;
            pre_d   = '0;
        end else if (start) begin
            state_d = RUN;
            limit_d = limit;
            mode_d  = mode;
            count_d = '0;
            pre_d   = '0;
        end else if (state_q == RUN) begin
            if (step) begin
                pre_d = '0;
                if (at_limit) begin
                    expire_d    = 1'b1;
                    set_reached = 1'b1;
                    if (mode_q) begin
                        count_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end

        // A new timeout outranks a simultaneous clear.
        if (set_reached) begin
            reached_d = 1'b1;
        end else if (clear) begin
            reached_d = 1'b0;
        end else begin
            reached_d = reached_q;
        end
    end

    always_ff @(posedge tick or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            pre_q     <= '0;
            mode_q    <= 1'b0;
            reached_q <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            pre_q     <= pre_d;
            mode_q    <= mode_d;
            reached_q <= reached_d;
            expire_q  <= expire_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign reached = reached_q;
    assign expire  = expire_q;

endmodule

// File: tb/tb_timeout_timer.sv
// Directed bench for timeout_timer: two instances (PRESCALE=1 and PRESCALE=4)
// share all inputs; each scenario task checks the instance it targets.
module tb_timeout_timer;

    logic        tick  = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        mode  = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] limit = 16'd0;

    logic [15:0] count1, count4;
    logic        running1, reached1, expire1;
    logic        running4, reached4, expire4;

    int checks = 0;
    int errors = 0;

    always #5 tick = ~tick;

    timeout_timer #(.WIDTH(16), .PRESCALE(1)) dut1 (
        .tick(tick), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .limit(limit), .clear(clear), .count(count1), .running(running1),
        .reached(reached1), .expire(expire1)
    );

    timeout_timer #(.WIDTH(16), .PRESCALE(4)) dut4 (
        .tick(tick), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .limit(limit), .clear(clear), .count(count4), .running(running4),
        .reached(reached4), .expire(expire4)
    );

    task automatic step_n(input int n);
        repeat (n) @(negedge tick);
    endtask

    // One-cycle start; limit/mode are then scrambled to show they are not re-sampled.
    task automatic kick(input logic [15:0] lim, input logic md);
        start = 1'b1;
        limit = lim;
        mode  = md;
        @(negedge tick);
        start = 1'b0;
        limit = 16'hFFFF;
        mode  = ~md;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (count1 !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count1); end
        checks++; if ({running1, reached1, expire1} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {running1, reached1, expire1}); end
        checks++; if ({count4, running4, reached4, expire4} !== 19'd0) begin errors++; $display("FAIL reset_dut4: got %h expected 0", {count4, running4, reached4, expire4}); end
        @(negedge tick);
        reset = 1'b1;
    endtask

    task automatic test_oneshot();
        kick(16'd10, 1'b0);
        step_n(10);
        checks++; if (count1 !== 16'd10) begin errors++; $display("FAIL oneshot_count10: got %0d expected 10", count1); end
        checks++; if (expire1 !== 1'b0) begin errors++; $display("FAIL oneshot_early_expire: got %b expected 0", expire1); end
        step_n(1);
        checks++; if (expire1 !== 1'b1) begin errors++; $display("FAIL oneshot_expire: got %b expected 1", expire1); end
        checks++; if (reached1 !== 1'b1) begin errors++; $display("FAIL oneshot_reached: got %b expected 1", reached1); end
        checks++; if (running1 !== 1'b0) begin errors++; $display("FAIL oneshot_running: got %b expected 0", running1); end
        checks++; if (count1 !== 16'd10) begin errors++; $display("FAIL oneshot_hold: got %0d expected 10", count1); end
        step_n(1);
        checks++; if (expire1 !== 1'b0) begin errors++; $display("FAIL oneshot_pulse_width: got %b expected 0", expire1); end
        checks++; if (reached1 !== 1'b1) begin errors++; $display("FAIL oneshot_sticky: got %b expected 1", reached1); end
        clear = 1'b1;
        step_n(1);
        clear = 1'b0;
        checks++; if (reached1 !== 1'b0) begin errors++; $display("FAIL clear_reached: got %b expected 0", reached1); end
    endtask

    task automatic test_periodic();
        logic [15:0] exp_cnt;
        logic        exp_exp;
        kick(16'd2, 1'b1);
        checks++; if (count4 !== 16'd0) begin errors++; $display("FAIL periodic_start_count: got %0d expected 0", count4); end
        for (int k = 1; k <= 36; k++) begin
            step_n(1);
            exp_cnt = 16'((k / 4) % 3);
            exp_exp = (k % 12 == 0);
            checks++; if (count4 !== exp_cnt) begin errors++; $display("FAIL periodic_count k=%0d: got %0d expected %0d", k, count4, exp_cnt); end
            checks++; if (expire4 !== exp_exp) begin errors++; $display("FAIL periodic_expire k=%0d: got %b expected %b", k, expire4, exp_exp); end
            checks++; if (running4 !== 1'b1) begin errors++; $display("FAIL periodic_running k=%0d: got %b expected 1", k, running4); end
        end
        stop = 1'b1;
        step_n(1);
        stop = 1'b0;
        checks++; if (running4 !== 1'b0) begin errors++; $display("FAIL periodic_stop: got %b expected 0", running4); end
        clear = 1'b1;
        step_n(1);
        clear = 1'b0;
    endtask

    task automatic test_stop();
        kick(16'd5, 1'b0);
        step_n(3);
        checks++; if (count1 !== 16'd3) begin errors++; $display("FAIL stop_pre_count: got %0d expected 3", count1); end
        stop = 1'b1;
        step_n(1);
        stop = 1'b0;
        checks++; if (running1 !== 1'b0) begin errors++; $display("FAIL stop_running: got %b expected 0", running1); end
        checks++; if (count1 !== 16'd3) begin errors++; $display("FAIL stop_hold: got %0d expected 3", count1); end
        step_n(3);
        checks++; if (count1 !== 16'd3) begin errors++; $display("FAIL stop_idle_hold: got %0d expected 3", count1); end
        checks++; if (expire1 !== 1'b0) begin errors++; $display("FAIL stop_no_expire: got %b expected 0", expire1); end
        kick(16'd5, 1'b0);
        checks++; if (count1 !== 16'd0 || running1 !== 1'b1) begin errors++; $display("FAIL restart: got count=%0d run=%b expected count=0 run=1", count1, running1); end
        step_n(5);
        checks++; if (count1 !== 16'd5 || expire1 !== 1'b0) begin errors++; $display("FAIL restart_count5: got count=%0d exp=%b expected count=5 exp=0", count1, expire1); end
        step_n(1);
        checks++; if (expire1 !== 1'b1) begin errors++; $display("FAIL restart_expire: got %b expected 1", expire1); end
        clear = 1'b1;
        step_n(1);
        clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        kick(16'd5, 1'b0);
        step_n(2);
        start = 1'b1;
        stop  = 1'b1;
        step_n(1);
        start = 1'b0;
        stop  = 1'b0;
        checks++; if (running1 !== 1'b0) begin errors++; $display("FAIL startstop_running: got %b expected 0", running1); end
        checks++; if (count1 !== 16'd2) begin errors++; $display("FAIL startstop_count: got %0d expected 2", count1); end
        kick(16'd2, 1'b0);
        step_n(2);
        clear = 1'b1;
        step_n(1);
        clear = 1'b0;
        checks++; if (expire1 !== 1'b1) begin errors++; $display("FAIL clear_vs_set_expire: got %b expected 1", expire1); end
        checks++; if (reached1 !== 1'b1) begin errors++; $display("FAIL clear_vs_set_reached: got %b expected 1", reached1); end
        clear = 1'b1;
        step_n(1);
        clear = 1'b0;
        kick(16'd2, 1'b0);
        step_n(2);
        kick(16'd3, 1'b0);
        checks++; if (expire1 !== 1'b0 || reached1 !== 1'b0) begin errors++; $display("FAIL start_over_expire: got exp=%b rch=%b expected 0 0", expire1, reached1); end
        checks++; if (count1 !== 16'd0 || running1 !== 1'b1) begin errors++; $display("FAIL start_over_expire_run: got count=%0d run=%b expected 0 1", count1, running1); end
        stop = 1'b1;
        step_n(1);
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        kick(16'd20, 1'b0);
        step_n(7);
        checks++; if (count1 !== 16'd7) begin errors++; $display("FAIL areset_pre_count: got %0d expected 7", count1); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({count1, running1, reached1, expire1} !== 19'd0) begin errors++; $display("FAIL areset_immediate: got %h expected 0", {count1, running1, reached1, expire1}); end
        checks++; if ({count4, running4, reached4, expire4} !== 19'd0) begin errors++; $display("FAIL areset_immediate_dut4: got %h expected 0", {count4, running4, reached4, expire4}); end
        start = 1'b1;
        limit = 16'd3;
        step_n(2);
        checks++; if (running1 !== 1'b0 || count1 !== 16'd0) begin errors++; $display("FAIL areset_ignore_inputs: got run=%b count=%0d expected 0 0", running1, count1); end
        start = 1'b0;
        reset = 1'b1;
        step_n(3);
        checks++; if ({count1, running1, expire1} !== 18'd0) begin errors++; $display("FAIL areset_stays_idle: got %h expected 0", {count1, running1, expire1}); end
    endtask

    task automatic test_limit0();
        kick(16'd0, 1'b1);
        checks++; if (count1 !== 16'd0 || expire1 !== 1'b0) begin errors++; $display("FAIL limit0_start: got count=%0d exp=%b expected 0 0", count1, expire1); end
        for (int k = 1; k <= 5; k++) begin
            step_n(1);
            checks++; if (expire1 !== 1'b1) begin errors++; $display("FAIL limit0_expire k=%0d: got %b expected 1", k, expire1); end
            checks++; if (count1 !== 16'd0 || running1 !== 1'b1) begin errors++; $display("FAIL limit0_state k=%0d: got count=%0d run=%b expected 0 1", k, count1, running1); end
        end
        stop = 1'b1;
        step_n(1);
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop();
        test_back_to_back();
        test_async_reset();
        test_limit0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
